apb_master_nch: RTL and testbench



---
 rtl/apb_master_nch.sv | 172 +++++++++++++++++
 tb/tb_apb_master_nch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_nch.sv
// APB requester that decodes a request address onto one of NUM_SLV completers.
// Optional access timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_nch #(
  parameter int unsigned       NUM_SLV     = 4,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       REGION_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned       TIMEOUT_CYC = 255
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic                      PENABLE,
  output logic [NUM_SLV-1:0]        PSEL,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  input  logic                      transfer,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      write,
  output logic                      busy,
  output logic                      ready,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err
);

  if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_param_err
    $error("apb_master_nch: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  localparam logic [4:0] NumSlv = 5'(NUM_SLV);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                write_q, write_d;
  logic [3:0]          idx_q, idx_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
`ifdef APB_TIMEOUT_EN
  logic [31:0]         cnt_q, cnt_d;
`endif

  logic [3:0]          req_idx;
  logic                hit;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;
  logic [NUM_SLV-1:0]  sel_onehot;

  assign req_idx = addr[REGION_W+3:REGION_W];
  assign hit     = (addr[ADDR_W-1:REGION_W+4] == BASE_ADDR[ADDR_W-1:REGION_W+4]) &&
                   ({1'b0, req_idx} < NumSlv);

  // Only the latched completer's response lines are ever looked at.
  always_comb begin
    sel_ready  = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == 4'(i)) begin
        sel_ready     = PREADY[i];
        sel_err       = PSLVERR[i];
        sel_rdata     = PRDATA[i*DATA_W +: DATA_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    write_d  = write_q;
    idx_d    = idx_q;
    ready_d  = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef APB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (transfer) begin
          if (hit) begin
            state_d  = StSetup;
            paddr_d  = addr;
            pwdata_d = wdata;
            write_d  = write;
            idx_d    = req_idx;
`ifdef APB_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            // Unmapped address completes immediately with an error.
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (sel_ready) begin
          state_d = StIdle;
          ready_d = 1'b1;
          rdata_d = write_q ? '0 : sel_rdata;
          err_d   = sel_err;
        end
`ifdef APB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_d == TIMEOUT_CYC) begin
            state_d = StIdle;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwdata_q <= '0;
      write_q  <= 1'b0;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      write_q  <= write_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign busy    = (state_q != StIdle);
  assign PENABLE = (state_q == StAccess);
  assign PSEL    = busy ? sel_onehot : '0;
  assign PWRITE  = busy & write_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign ready   = ready_q;
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_apb_master_nch.sv
// Self-checking bench for apb_master_nch: per-cycle expectation table built from
// transaction-level rules, checked every cycle, plus literal pins on key results.
module tb_apb_master_nch;
  localparam int NS    = 4;
  localparam int ToCyc = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic [31:0]  PADDR, PWDATA;
  logic         PWRITE, PENABLE;
  logic [3:0]   PSEL;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;
  logic         transfer, write;
  logic [31:0]  addr, wdata;
  logic         busy, ready, err;
  logic [31:0]  rdata;

  always #5 PCLK = ~PCLK;

  apb_master_nch #(
    .NUM_SLV(NS), .ADDR_W(32), .DATA_W(32), .REGION_W(12),
    .BASE_ADDR(32'h1000_0000), .TIMEOUT_CYC(ToCyc)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .transfer(transfer), .addr(addr), .wdata(wdata), .write(write),
    .busy(busy), .ready(ready), .rdata(rdata), .err(err)
  );

  typedef struct packed {
    logic [3:0]  psel;
    logic        pen;
    logic        pwrite;
    logic        busy;
    logic        rdy;
    logic        err;
    logic        upd;
    logic [31:0] rdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } exp_t;

  exp_t ev [0:2047];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;

  int         run_len = 0, pen_len = 0, last_len = 0, last_pen = 0, last_rdy_cyc = -1;
  logic [3:0] run_val = '0, last_val = '0;
  logic [31:0] m_paddr = '0, m_pwdata = '0, m_rdata = '0;
  logic        m_err = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare process: outputs against the expectation table on every falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        m_paddr = '0; m_pwdata = '0; m_rdata = '0; m_err = 1'b0;
        run_len = 0; pen_len = 0;
        chk("rst_psel", 32'(PSEL), 32'h0);
        chk("rst_penable", 32'(PENABLE), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
      end else if (chk_en) begin
        e = ev[cyc];
        if (e.upd) begin m_paddr = e.paddr; m_pwdata = e.pwdata; end
        if (e.rdy) begin m_rdata = e.rdata; m_err = e.err; end
        chk("psel", 32'(PSEL), 32'(e.psel));
        chk("penable", 32'(PENABLE), 32'(e.pen));
        chk("pwrite", 32'(PWRITE), 32'(e.pwrite));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("ready", 32'(ready), 32'(e.rdy));
        chk("paddr", PADDR, m_paddr);
        chk("pwdata", PWDATA, m_pwdata);
        chk("rdata", rdata, m_rdata);
        chk("err", 32'(err), 32'(m_err));
        if (PSEL != 4'h0) begin
          run_len++; run_val = PSEL; pen_len += int'(PENABLE);
        end else if (run_len != 0) begin
          last_len = run_len; last_val = run_val; last_pen = pen_len;
          run_len = 0; pen_len = 0;
        end
        if (ready) last_rdy_cyc = cyc;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  // Issues one request (called #1 after a rising edge) and returns in its ready cycle.
  task automatic do_xfer(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                         input int waits, input logic [31:0] rd, input logic se,
                         input bit extra);
    int c, idx, n_acc;
    bit hit, abort;
    c     = cyc;
    idx   = int'(a[15:12]);
    hit   = (a[31:16] == 16'h1000) && (idx < NS);
    abort = 1'b0;
    n_acc = 0;
    if (hit) begin
      abort = ToEn && (waits >= ToCyc);
      n_acc = abort ? ToCyc : waits + 1;
      for (int k = 1; k <= 1 + n_acc; k++) begin
        ev[c+k].psel   = 4'(1 << idx);
        ev[c+k].busy   = 1'b1;
        ev[c+k].pwrite = wr;
        ev[c+k].pen    = (k >= 2);
      end
      ev[c+1].upd    = 1'b1;
      ev[c+1].paddr  = a;
      ev[c+1].pwdata = wd;
      ev[c+2+n_acc].rdy   = 1'b1;
      ev[c+2+n_acc].err   = abort ? 1'b1 : se;
      ev[c+2+n_acc].rdata = (abort || wr) ? 32'h0 : rd;
    end else begin
      ev[c+1].rdy   = 1'b1;
      ev[c+1].err   = 1'b1;
      ev[c+1].rdata = 32'h0;
    end
    addr = a; wdata = wd; write = wr; transfer = 1'b1;
    // Unselected completers present ready/error/junk that must be ignored.
    PREADY  = hit ? ~4'(1 << idx) : 4'hF;
    PSLVERR = hit ? ~4'(1 << idx) : 4'hF;
    PRDATA  = {4{32'hBAD0_BAD0}};
    if (hit) begin
      for (int k = 1; k <= 1 + n_acc; k++) begin
        @(posedge PCLK); #1;
        transfer = extra;
        if (extra) begin addr = 32'h1000_0000; write = 1'b1; wdata = 32'h5555_5555; end
        if (!abort && k == 2 + waits) begin
          PREADY[idx]            = 1'b1;
          PRDATA[idx*32 +: 32]   = rd;
          PSLVERR[idx]           = se;
        end
      end
    end
    @(posedge PCLK); #1;
    transfer = 1'b0;
    PREADY   = 4'hF;
    PSLVERR  = 4'h0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < 2048; i++) ev[i] = '0;
    transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    PREADY = 4'hF; PSLVERR = 4'h0; PRDATA = '0;
    repeat (3) @(posedge PCLK);
    #2 PRESETn = 1'b1;
    chk_en = 1'b1;
    @(posedge PCLK); #1;
    idle(2);

    // Zero-wait write to completer 1
    t = cyc;
    do_xfer(32'h1000_1004, 32'hDEAD_BEEF, 1'b1, 0, 32'h0, 1'b0, 1'b0);
    idle(1);
    chk("w_psel_val", 32'(last_val), 32'h2);
    chk("w_psel_len", 32'(last_len), 32'd2);
    chk("w_pen_len", 32'(last_pen), 32'd1);
    chk("w_latency", 32'(last_rdy_cyc - t), 32'd3);
    chk("w_err", 32'(err), 32'h0);

    // Read from completer 3 with two wait states
    do_xfer(32'h1000_3010, 32'h0, 1'b0, 2, 32'h1234_5678, 1'b0, 1'b0);
    chk("r_ready", 32'(ready), 32'h1);
    chk("r_rdata", rdata, 32'h1234_5678);
    idle(1);
    chk("r_pen_len", 32'(last_pen), 32'd3);
    chk("r_psel_val", 32'(last_val), 32'h8);

    // Unmapped addresses: foreign window and out-of-range index
    do_xfer(32'h2000_0000, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    chk("u_ready", 32'(ready), 32'h1);
    chk("u_err", 32'(err), 32'h1);
    chk("u_rdata", rdata, 32'h0);
    chk("u_psel", 32'(PSEL), 32'h0);
    do_xfer(32'h1000_5000, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    idle(1);

    // Slave error, with transfer held high while busy
    do_xfer(32'h1000_2000, 32'h0, 1'b0, 1, 32'hCAFE_F00D, 1'b1, 1'b1);
    chk("e_ready", 32'(ready), 32'h1);
    chk("e_err", 32'(err), 32'h1);
    idle(2);
    chk("e_hold_err", 32'(err), 32'h1);

    // Back-to-back: next request issued in the ready cycle
    do_xfer(32'h1000_0100, 32'h0BAD_CAFE, 1'b1, 0, 32'h0, 1'b0, 1'b0);
    do_xfer(32'h1000_1200, 32'h0, 1'b0, 1, 32'h8765_4321, 1'b0, 1'b0);
    chk("b_rdata", rdata, 32'h8765_4321);
    idle(2);

    if (ToEn) begin
      do_xfer(32'h1000_0000, 32'h0, 1'b0, 10, 32'h1, 1'b0, 1'b0);
      chk("t_ready", 32'(ready), 32'h1);
      chk("t_err", 32'(err), 32'h1);
      chk("t_rdata", rdata, 32'h0);
      idle(1);
      chk("t_pen_len", 32'(last_pen), 32'd4);
    end

    // Reset during ACCESS
    chk_en = 1'b0;
    t = cyc;
    addr = 32'h1000_0040; write = 1'b1; wdata = 32'h7777_0000; transfer = 1'b1;
    PREADY = 4'hE;
    idle(1);
    transfer = 1'b0;
    idle(1);
    chk("x_penable", 32'(PENABLE), 32'h1);
    chk("x_psel", 32'(PSEL), 32'h1);
    #2 PRESETn = 1'b0;
    #1;
    chk("x_psel0", 32'(PSEL), 32'h0);
    chk("x_pen0", 32'(PENABLE), 32'h0);
    chk("x_pwrite0", 32'(PWRITE), 32'h0);
    chk("x_busy0", 32'(busy), 32'h0);
    chk("x_paddr0", PADDR, 32'h0);
    chk("x_pwdata0", PWDATA, 32'h0);
    chk("x_rdata0", rdata, 32'h0);
    chk("x_err0", 32'(err), 32'h0);
    for (int i = t; i < t + 64; i++) ev[i] = '0;
    PREADY = 4'hF;
    @(posedge PCLK);
    #2 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk_en = 1'b1;
    chk("x_ready_none", 32'(ready), 32'h0);
    do_xfer(32'h1000_0008, 32'hA5A5_0001, 1'b0, 1, 32'h0F0F_0F0F, 1'b0, 1'b0);
    chk("x_after_rdata", rdata, 32'h0F0F_0F0F);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
